dbg_req_bridge: RTL and testbench
=================================

DBG_REQ_BRIDGE -- requirements
Module: dbg_req_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, which sets the debug address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 65, which sets the debug data width (bits 64:0).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, which sets the stall limit in cycles (range 1..65535).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk_i input 1 is the clock, sampled on the rising edge only.
REQ-005 rst_i input 1: synchronous reset, active high.
REQ-006 cmd_valid_i input 1; cmd_ready_o output 1: upstream command handshake.
REQ-007 cmd_addr_i input ADDR_WIDTH; cmd_we_i input 1; cmd_wdata_i input DATA_WIDTH: command payload.
REQ-008 resp_valid_o output 1; resp_ready_i input 1: response handshake.
REQ-009 resp_rdata_o output DATA_WIDTH; resp_err_o output 1: response payload.
REQ-010 dbg_req_o output 1; dbg_gnt_i input 1; dbg_rvalid_i input 1: debug bus master-side control.
REQ-011 dbg_addr_o output ADDR_WIDTH; dbg_we_o output 1; dbg_wdata_o output DATA_WIDTH; dbg_rdata_i input DATA_WIDTH: debug bus master-side data.
REQ-012 busy_o output 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, REQ, WAIT and RESP, and SHALL keep at most one transaction outstanding.
REQ-014 IDLE: cmd_ready_o=1; cmd_valid_i=1 latches addr/we/wdata into holding registers and moves to REQ on the next cycle.
REQ-015 REQ: dbg_req_o=1 with addr/we/wdata stable from the holding registers; dbg_gnt_i=1 -> WAIT, unless dbg_rvalid_i=1 in the same cycle, in which case -> RESP with data captured.
REQ-016 WAIT: dbg_req_o=0; dbg_rvalid_i=1 captures dbg_rdata_i into resp_rdata_o, sets err=0 and -> RESP.
REQ-017 Every granted transaction, read or write, SHALL complete with one rvalid; for writes the captured rdata is passed through unchanged.
REQ-018 RESP: resp_valid_o=1 with payload held stable; resp_ready_i=1 -> IDLE.
REQ-019 Minimum latency from command acceptance to resp_valid_o SHALL be 2 cycles (gnt and rvalid in the first REQ cycle).
REQ-020 dbg_rvalid_i SHALL be ignored outside REQ and WAIT, so stale or late responses are dropped.
REQ-021 cmd_ready_o SHALL be 0 in REQ, WAIT and RESP, so there is no back-to-back acceptance without passing through IDLE.
REQ-022 When the bus is idle, dbg_addr_o, dbg_we_o and dbg_wdata_o SHALL hold their last values (no X, no toggling).

Reset
REQ-023 rst_i=1 SHALL force IDLE, clear the holding registers and set resp_rdata_o=0, resp_err_o=0, resp_valid_o=0, dbg_req_o=0, dbg_we_o=0, dbg_addr_o=0, dbg_wdata_o=0, busy_o=0 and cmd_ready_o=0 during reset.
REQ-024 Reset in any state SHALL abort the transaction with no response issued; cmd_ready_o=1 from the first cycle after rst_i falls.

Configuration
REQ-025 With macro DBG_REQ_BRIDGE_TIMEOUT_EN defined, a counter SHALL increment each cycle in REQ or WAIT and clear on entry to REQ.
REQ-026 With the macro defined, when the count reaches TIMEOUT_CYCLES, the FSM -> RESP with resp_err_o=1, resp_rdata_o=0 and dbg_req_o dropped; a gnt or rvalid arriving in the same cycle wins over the timeout.
REQ-027 Without the macro, no counter SHALL exist, the FSM waits indefinitely and resp_err_o is tied to 0.

Structure
REQ-028 Package dbg_bridge_pkg SHALL hold the state enum type (dbg_bridge_state_e), the default widths, the default TIMEOUT_CYCLES, and a packed command struct (addr, we, wdata).
REQ-029 Sub-module dbg_bridge_timer (clear/enable inputs, expired output) SHALL hold the timeout counter and be instantiated only under DBG_REQ_BRIDGE_TIMEOUT_EN.

Verification
REQ-030 Read cmd addr=0x0040, we=0; gnt 1 cycle after req; rvalid 2 cycles later with rdata=0x1_DEAD_BEEF -> resp_rdata_o=0x1_DEAD_BEEF, err=0, busy_o high throughout.
REQ-031 Write addr=0x7FFF, wdata=0x1_0000_0000_0000_0001; gnt held low 5 cycles -> dbg_req_o high for 6 cycles with payload stable, then resp returned after rvalid.
REQ-032 gnt and rvalid in the same cycle as the first req -> resp_valid_o asserted 2 cycles after cmd acceptance.
REQ-033 resp_ready_i held low 4 cycles -> payload stable; a new cmd_valid_i is not accepted until 1 cycle after resp_ready_i.
REQ-034 With macro defined and TIMEOUT_CYCLES=8, gnt never asserted -> after 8 cycles in REQ, resp_err_o=1 and rdata=0; a later rvalid is ignored.
REQ-035 rst_i pulsed while in WAIT -> all outputs at reset values, no resp_valid_o, and the next command completes normally.

Source files
------------

// File: rtl/dbg_bridge_pkg.sv
// rtl/dbg_bridge_pkg.sv - shared types and defaults for the debug request bridge
package dbg_bridge_pkg;

    localparam int DBG_ADDR_WIDTH     = 15;
    localparam int DBG_DATA_WIDTH     = 65;
    localparam int DBG_TIMEOUT_CYCLES = 255;

    // Bridge FSM states; one transaction in flight at most
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dbg_bridge_state_e;

    // Command as accepted from upstream, at the default widths
    typedef struct packed {
        logic [DBG_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [DBG_DATA_WIDTH-1:0] wdata;
    } dbg_cmd_t;

endpackage

// File: rtl/dbg_bridge_timer.sv
// rtl/dbg_bridge_timer.sv - stall counter flagging when a bus transaction has waited too long
module dbg_bridge_timer
    import dbg_bridge_pkg::*;
#(
    parameter int LIMIT = DBG_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    // Count stalled cycles; saturate so a held enable cannot wrap around
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            count <= '0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    // Count starts at 0 in the first stalled cycle, so LIMIT-1 marks the LIMIT-th cycle
    assign expired = enable && (count >= 16'(LIMIT - 1));

endmodule

// File: rtl/dbg_req_bridge.sv
// rtl/dbg_req_bridge.sv - single-outstanding command-to-debug-bus bridge (optional timeout: DBG_REQ_BRIDGE_TIMEOUT_EN)
module dbg_req_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = DBG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DBG_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DBG_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic                  cmd_we_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  dbg_req_o,
    input  logic                  dbg_gnt_i,
    input  logic                  dbg_rvalid_i,
    output logic [ADDR_WIDTH-1:0] dbg_addr_o,
    output logic                  dbg_we_o,
    output logic [DATA_WIDTH-1:0] dbg_wdata_o,
    input  logic [DATA_WIDTH-1:0] dbg_rdata_i,
    output logic                  busy_o
);

    dbg_bridge_state_e     state;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic                  hold_we;
    logic [DATA_WIDTH-1:0] hold_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  dbg_req;
    logic                  timeout_hit;

`ifdef DBG_REQ_BRIDGE_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;

    // Restart the stall count whenever a command is accepted into REQ
    assign timer_clear  = (state == ST_IDLE) && cmd_valid_i;
    assign timer_enable = (state == ST_REQ) || (state == ST_WAIT);

    dbg_bridge_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;

    // Without the timeout the bridge waits on the bus indefinitely
    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            hold_addr  <= '0;
            hold_we    <= 1'b0;
            hold_wdata <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            dbg_req    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        hold_addr  <= cmd_addr_i;
                        hold_we    <= cmd_we_i;
                        hold_wdata <= cmd_wdata_i;
                        dbg_req    <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dbg_gnt_i && dbg_rvalid_i) begin
                        dbg_req    <= 1'b0;
                        resp_rdata <= dbg_rdata_i;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (dbg_gnt_i) begin
                        dbg_req <= 1'b0;
                        state   <= ST_WAIT;
                    end else if (timeout_hit) begin
                        dbg_req    <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (dbg_rvalid_i) begin
                        resp_rdata <= dbg_rdata_i;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (timeout_hit) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    dbg_req    <= 1'b0;
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by reset so it only rises once reset is released
    assign cmd_ready_o  = (state == ST_IDLE) && !rst_i;
    assign busy_o       = (state != ST_IDLE);
    assign resp_valid_o = resp_valid;
    assign resp_rdata_o = resp_rdata;
    assign resp_err_o   = resp_err;
    assign dbg_req_o    = dbg_req;
    assign dbg_addr_o   = hold_addr;
    assign dbg_we_o     = hold_we;
    assign dbg_wdata_o  = hold_wdata;

endmodule

// File: tb/tb_dbg_req_bridge.sv
// tb/tb_dbg_req_bridge.sv - scoreboard bench for dbg_req_bridge
module tb_dbg_req_bridge;

    localparam int AW = 15;
    localparam int DW = 65;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_we;
    logic [DW-1:0] cmd_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          dbg_req;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic          dbg_we;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          busy;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    dbg_req_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_we_i     (cmd_we),
        .cmd_wdata_i  (cmd_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .dbg_req_o    (dbg_req),
        .dbg_gnt_i    (dbg_gnt),
        .dbg_rvalid_i (dbg_rvalid),
        .dbg_addr_o   (dbg_addr),
        .dbg_we_o     (dbg_we),
        .dbg_wdata_o  (dbg_wdata),
        .dbg_rdata_i  (dbg_rdata),
        .busy_o       (busy)
    );

    // Scoreboard: each new response is matched against the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resp_valid === 1'b1 && prev_valid !== 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: resp_valid with nothing expected, rdata=%h err=%b", resp_rdata, resp_err);
            end else begin
                e = sbq.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    failures++;
                    $display("FAIL sb_payload: got rdata=%h err=%b, expected rdata=%h err=%b", resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
        prev_valid <= resp_valid;
    end

    task automatic push_exp(input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        sbq.push_back(e);
    endtask

    // Present a command for one cycle; called at a negedge with the DUT idle
    task automatic drive_cmd(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_we    = we;
        cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input int budget);
        for (int i = 0; i < budget && resp_valid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_wdata = '0;
        resp_ready = 1'b0; dbg_gnt = 1'b0; dbg_rvalid = 1'b0; dbg_rdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, dbg_req, resp_valid, resp_err, dbg_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready/busy/req/valid/err/we=%b expected 000000", {cmd_ready, busy, dbg_req, resp_valid, resp_err, dbg_we});
        end
        checks++;
        if (dbg_addr !== '0 || dbg_wdata !== '0 || resp_rdata !== '0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected all 0", dbg_addr, dbg_wdata, resp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: cmd_ready=%b expected 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL read_ready: cmd_ready=%b expected 1", cmd_ready);
        end
        push_exp(65'h1_DEAD_BEEF, 1'b0);
        drive_cmd(15'h0040, 1'b0, '0);
        checks++;
        if (dbg_req !== 1'b1 || dbg_addr !== 15'h0040 || dbg_we !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL read_req: req=%b addr=%h we=%b busy=%b ready=%b expected 1 0040 0 1 0", dbg_req, dbg_addr, dbg_we, busy, cmd_ready);
        end
        @(negedge clk);
        dbg_gnt = 1'b1;
        @(negedge clk);
        dbg_gnt = 1'b0;
        checks++;
        if (dbg_req !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL read_wait: req=%b busy=%b expected 0 1", dbg_req, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_wait2: busy=%b resp_valid=%b expected 1 0", busy, resp_valid);
        end
        dbg_rvalid = 1'b1;
        dbg_rdata  = 65'h1_DEAD_BEEF;
        @(negedge clk);
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        checks++;
        if (resp_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL read_resp: resp_valid=%b busy=%b expected 1 1", resp_valid, busy);
        end
        finish_resp();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL read_idle: valid=%b busy=%b ready=%b expected 0 0 1", resp_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_write_stall();
        int req_cycles = 0;
        push_exp(65'h0_1234_5678, 1'b0);
        drive_cmd(15'h7FFF, 1'b1, 65'h1_0000_0000_0000_0001);
        for (int i = 0; i < 6; i++) begin
            if (dbg_req === 1'b1) req_cycles++;
            checks++;
            if (dbg_addr !== 15'h7FFF || dbg_we !== 1'b1 || dbg_wdata !== 65'h1_0000_0000_0000_0001) begin
                failures++;
                $display("FAIL write_payload cycle %0d: addr=%h we=%b wdata=%h", i, dbg_addr, dbg_we, dbg_wdata);
            end
            if (i == 5) dbg_gnt = 1'b1;
            @(negedge clk);
        end
        dbg_gnt = 1'b0;
        checks++;
        if (req_cycles != 6 || dbg_req !== 1'b0) begin
            failures++;
            $display("FAIL write_req_len: req cycles=%0d req_now=%b expected 6 and 0", req_cycles, dbg_req);
        end
        dbg_rvalid = 1'b1;
        dbg_rdata  = 65'h0_1234_5678;
        @(negedge clk);
        dbg_rvalid = 1'b0;
        wait_resp(4);
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_resp: resp_valid=%b expected 1", resp_valid);
        end
        finish_resp();
    endtask

    task automatic test_fast();
        push_exp(65'h0_CAFE_F00D, 1'b0);
        drive_cmd(15'h0123, 1'b0, '0);
        dbg_gnt = 1'b1; dbg_rvalid = 1'b1; dbg_rdata = 65'h0_CAFE_F00D;
        checks++;
        if (dbg_req !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL fast_c1: req=%b resp_valid=%b expected 1 0", dbg_req, resp_valid);
        end
        @(negedge clk);
        dbg_gnt = 1'b0; dbg_rvalid = 1'b0; dbg_rdata = '0;
        checks++;
        if (resp_valid !== 1'b1 || dbg_req !== 1'b0) begin
            failures++;
            $display("FAIL fast_latency: resp_valid=%b req=%b two cycles after accept, expected 1 0", resp_valid, dbg_req);
        end
        finish_resp();
    endtask

    task automatic test_backpressure();
        push_exp(65'h1_5555_AAAA, 1'b0);
        drive_cmd(15'h0AAA, 1'b0, '0);
        dbg_gnt = 1'b1; dbg_rvalid = 1'b1; dbg_rdata = 65'h1_5555_AAAA;
        @(negedge clk);
        dbg_gnt = 1'b0; dbg_rvalid = 1'b0; dbg_rdata = '0;
        cmd_valid = 1'b1; cmd_addr = 15'h0BBB; cmd_we = 1'b0; cmd_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 65'h1_5555_AAAA || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h ready=%b", i, resp_valid, resp_rdata, cmd_ready);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || dbg_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle: ready=%b req=%b busy=%b expected 1 0 0", cmd_ready, dbg_req, busy);
        end
        push_exp(65'h0_0000_0BBB, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (dbg_req !== 1'b1 || dbg_addr !== 15'h0BBB) begin
            failures++;
            $display("FAIL bp_next: req=%b addr=%h expected 1 0bbb", dbg_req, dbg_addr);
        end
        dbg_gnt = 1'b1; dbg_rvalid = 1'b1; dbg_rdata = 65'h0_0000_0BBB;
        @(negedge clk);
        dbg_gnt = 1'b0; dbg_rvalid = 1'b0; dbg_rdata = '0;
        finish_resp();
    endtask

    task automatic test_stale_rvalid();
        dbg_rvalid = 1'b1;
        dbg_rdata  = 65'h1_FFFF_FFFF;
        repeat (2) @(negedge clk);
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_rdata === 65'h1_FFFF_FFFF) begin
            failures++;
            $display("FAIL stale_rvalid: valid=%b busy=%b rdata=%h expected idle, rvalid dropped", resp_valid, busy, resp_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        drive_cmd(15'h0321, 1'b1, 65'h0_0000_9999);
        dbg_gnt = 1'b1;
        @(negedge clk);
        dbg_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, dbg_req, resp_valid, resp_err, dbg_we} !== 6'b0 || dbg_addr !== '0 || dbg_wdata !== '0 || resp_rdata !== '0) begin
            failures++;
            $display("FAIL rst_wait: ready/busy/req/valid/err/we=%b addr=%h wdata=%h rdata=%h expected all 0", {cmd_ready, busy, dbg_req, resp_valid, resp_err, dbg_we}, dbg_addr, dbg_wdata, resp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_ready: cmd_ready=%b expected 1", cmd_ready);
        end
        @(negedge clk);
        dbg_rvalid = 1'b1;
        dbg_rdata  = 65'h0_0BAD_0BAD;
        @(negedge clk);
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_noresp: valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
        push_exp(65'h1_0000_0042, 1'b0);
        drive_cmd(15'h0042, 1'b0, '0);
        dbg_gnt = 1'b1; dbg_rvalid = 1'b1; dbg_rdata = 65'h1_0000_0042;
        @(negedge clk);
        dbg_gnt = 1'b0; dbg_rvalid = 1'b0; dbg_rdata = '0;
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_next: resp_valid=%b expected 1", resp_valid);
        end
        finish_resp();
    endtask

`ifdef DBG_REQ_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles = 0;
        push_exp('0, 1'b1);
        drive_cmd(15'h0555, 1'b0, '0);
        for (int i = 0; i < 12 && resp_valid !== 1'b1; i++) begin
            if (dbg_req === 1'b1) req_cycles++;
            @(negedge clk);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || req_cycles != 8 || dbg_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout: valid=%b err=%b req_cycles=%0d req=%b expected 1 1 8 0", resp_valid, resp_err, req_cycles, dbg_req);
        end
        dbg_rvalid = 1'b1;
        dbg_rdata  = 65'h1_2222_3333;
        @(negedge clk);
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        checks++;
        if (resp_rdata !== '0 || resp_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_late_rvalid: rdata=%h err=%b expected 0 1", resp_rdata, resp_err);
        end
        finish_resp();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_fast();
        test_backpressure();
        test_stale_rvalid();
        test_reset_in_wait();
`ifdef DBG_REQ_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d responses still expected, required 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
